// File: rtl/run_det_pkg.sv
// Shared types and helpers for the run-length detector.
// Pure declarations, no latency.
// No flow control involved.
package run_det_pkg;

    typedef enum logic [1:0] {
        MODE_BOTH = 2'b00,
        MODE_ZERO = 2'b01,
        MODE_ONE  = 2'b10,
        MODE_OFF  = 2'b11
    } mode_t;

    // Width able to hold 0..run_len without wrapping.
    function automatic int cnt_width(input int run_len);
        return $clog2(run_len + 1);
    endfunction

    // True when a run of polarity pol is reportable under mode.
    function automatic logic pol_enabled(input logic [1:0] mode, input logic pol);
        case (mode_t'(mode))
            MODE_BOTH: return 1'b1;
            MODE_ZERO: return !pol;
            MODE_ONE:  return pol;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, sticks at all-ones; clear wins over increment.
// Output registered, increment visible the cycle after i_inc.
// No backpressure; increments beyond saturation are dropped.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Count qualified increments, hold at all-ones, clear synchronously.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/run_length_detector.sv
// Flags RUN_LEN consecutive equal qualified samples of i_w, with hit pulse and hit counter.
// z/z0/z1 one cycle after the completing sample edge; mode gating is combinational.
// No backpressure; samples are taken only on edges with i_en=1, otherwise state holds.
module run_length_detector
    import run_det_pkg::*;
#(
    parameter  int RUN_LEN = 4,
    parameter  int HIT_W   = 8,
    localparam int CNT_W   = cnt_width(RUN_LEN)
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             i_en,
    input  logic             i_sclr,
    input  logic             i_w,
    input  logic [1:0]       i_mode,
    output logic             o_z,
    output logic             o_z0,
    output logic             o_z1,
    output logic             o_hit,
    output logic [CNT_W-1:0] o_run_cnt,
    output logic             o_last,
    output logic [HIT_W-1:0] o_hit_cnt
);

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] RUN_PRE = CNT_W'(RUN_LEN - 1);

    logic [CNT_W-1:0] r_run_cnt;
    logic             r_last;
    logic             r_hit;

    logic             w_extend;
    logic [CNT_W-1:0] w_run_nxt;
    logic             w_hit_set;
    logic             w_full;

    // run_cnt==0 means no sample seen yet, so the first sample always extends.
    assign w_extend  = (r_run_cnt == '0) || (i_w == r_last);
    assign w_run_nxt = !w_extend               ? CNT_W'(1) :
                       (r_run_cnt == RUN_MAX)  ? RUN_MAX   :
                                                 r_run_cnt + CNT_W'(1);

    // Only the transition RUN_LEN-1 -> RUN_LEN can hit, so saturated runs and
    // mid-run mode changes never pulse. RUN_LEN>=2 keeps this off the empty state.
    assign w_hit_set = i_en && !i_sclr && (r_run_cnt == RUN_PRE) &&
                       (i_w == r_last) && pol_enabled(i_mode, i_w);

    // Run tracker and hit pulse; sync clear beats sample enable.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_run_cnt <= '0;
            r_last    <= 1'b0;
            r_hit     <= 1'b0;
        end else if (i_sclr) begin
            r_run_cnt <= '0;
            r_last    <= 1'b0;
            r_hit     <= 1'b0;
        end else if (i_en) begin
            r_run_cnt <= w_run_nxt;
            r_last    <= i_w;
            r_hit     <= w_hit_set;
        end else begin
            r_hit     <= 1'b0;
        end
    end

    sat_counter #(
        .W (HIT_W)
    ) u_hit_cnt (
        .clk   (clk),
        .aclr  (aclr),
        .i_inc (w_hit_set),
        .i_clr (i_sclr),
        .o_q   (o_hit_cnt)
    );

    assign w_full    = (r_run_cnt == RUN_MAX);
    assign o_z0      = w_full && !r_last;
    assign o_z1      = w_full &&  r_last;
    assign o_z       = (o_z0 && pol_enabled(i_mode, 1'b0)) ||
                       (o_z1 && pol_enabled(i_mode, 1'b1));
    assign o_hit     = r_hit;
    assign o_run_cnt = r_run_cnt;
    assign o_last    = r_last;

endmodule
